// File: rtl/audio_i2s_out_pkg.sv
// Shared constants and sample type for the audio output path (PSG/PCM mix and I2S serialiser).
package audio_pkg;

  localparam int FRAME_CYCLES    = 512;
  localparam int BCK_HALF_CYCLES = 4;
  localparam int SLOTS_PER_CH    = 32;
  localparam int SAMPLE_W        = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/audio_i2s_out_if.sv
// Sample inputs, frame strobe and I2S pins of audio_i2s_out.
// Handshake: no valid/ready; producers hold samples stable and update them only after a next_sample strobe.
interface audio_i2s_out_if;
  import audio_pkg::*;

  sample_t psg_left;
  sample_t psg_right;
  sample_t pcm_left;
  sample_t pcm_right;
  logic    next_sample;
  logic    i2s_lrck;
  logic    i2s_bck;
  logic    i2s_data;

  modport master (
    output psg_left, psg_right, pcm_left, pcm_right,
    input  next_sample, i2s_lrck, i2s_bck, i2s_data
  );

  modport slave (
    input  psg_left, psg_right, pcm_left, pcm_right,
    output next_sample, i2s_lrck, i2s_bck, i2s_data
  );

endinterface

// File: rtl/audio_i2s_out_sat_add.sv
// Signed 18-bit add with clamp to the 16-bit sample range.
module audio_sat_add
  import audio_pkg::*;
(
  input  logic signed [17:0] a,
  input  logic signed [17:0] b,
  output sample_t            y
);

  // One extra bit so a shifted full-scale PSG plus PCM cannot wrap before the clamp.
  logic signed [18:0] sum;

  assign sum = {a[17], a} + {b[17], b};

  always_comb begin
    y = sum[15:0];
    if (sum > 19'sd32767) begin
      y = SAT_MAX;
    end else if (sum < -19'sd32768) begin
      y = SAT_MIN;
    end
  end

endmodule

// File: rtl/audio_i2s_out.sv
// Frame timer, PSG/PCM stereo mixer and I2S serialiser; 512 clk per frame, BCK = clk/8.
// Define AUDIO_I2S_OUT_PCM_MIX_EN to mix the PCM inputs; otherwise they are ignored.
module audio_i2s_out
  import audio_pkg::*;
#(
  parameter int PSG_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  audio_i2s_out_if.slave bus
);

  localparam int CNT_W   = $clog2(FRAME_CYCLES);
  localparam int BCK_BIT = $clog2(BCK_HALF_CYCLES);
  localparam int SR_W    = 2 * SLOTS_PER_CH;

  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_d;
  logic             next_q;
  logic             lrck_q;
  logic             bck_q;
  logic             data_q;

  logic signed [17:0] psg_l_ext;
  logic signed [17:0] psg_r_ext;
  logic signed [17:0] pcm_l_ext;
  logic signed [17:0] pcm_r_ext;
  sample_t            mix_l;
  sample_t            mix_r;

  assign psg_l_ext = {{2{bus.psg_left[15]}},  bus.psg_left}  <<< PSG_SHIFT;
  assign psg_r_ext = {{2{bus.psg_right[15]}}, bus.psg_right} <<< PSG_SHIFT;

`ifdef AUDIO_I2S_OUT_PCM_MIX_EN
  assign pcm_l_ext = {{2{bus.pcm_left[15]}},  bus.pcm_left};
  assign pcm_r_ext = {{2{bus.pcm_right[15]}}, bus.pcm_right};
`else
  assign pcm_l_ext = '0;
  assign pcm_r_ext = '0;
`endif

  audio_sat_add u_sat_l (.a(psg_l_ext), .b(pcm_l_ext), .y(mix_l));
  audio_sat_add u_sat_r (.a(psg_r_ext), .b(pcm_r_ext), .y(mix_r));

  // Slot 0 of each half is the I2S one-BCK delay; slots 17..31 pad with zero.
  always_comb begin
    sr_d = sr;
    if (cnt == '0) begin
      sr_d = {1'b0, mix_l, 15'b0, 1'b0, mix_r, 15'b0};
    end else if (cnt[BCK_BIT:0] == '0) begin
      sr_d = {sr[SR_W-2:0], 1'b0};
    end
  end

  // data_q takes the post-update MSB so it shifts on the same edge bck_q falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sr     <= '0;
      next_q <= 1'b0;
      lrck_q <= 1'b0;
      bck_q  <= 1'b0;
      data_q <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      sr     <= sr_d;
      next_q <= (cnt == CNT_W'(FRAME_CYCLES - 1));
      lrck_q <= cnt[CNT_W-1];
      bck_q  <= cnt[BCK_BIT];
      data_q <= sr_d[SR_W-1];
    end
  end

  assign bus.next_sample = next_q;
  assign bus.i2s_lrck    = lrck_q;
  assign bus.i2s_bck     = bck_q;
  assign bus.i2s_data    = data_q;

endmodule
